dm_responder: RTL and testbench
===============================

Name: dm_responder

Overview:
Memory-side responder for the pipeline's data-memory interface. The M stage acts as initiator and issues load/store requests over a valid/ready handshake. This block accepts one request at a time, applies a fixed programmable access latency, and performs a byte-enabled read or write on an internal word array. It returns a one-cycle response and exposes Busy for the stall controller.

Parameters:
ADDR_W, 12, word-index width; array holds 2^ADDR_W 32-bit words (16 KiB default)
LATENCY, 2, cycles from request acceptance to Resp_Valid; legal range 1..15

Ports:
Clk  input  1  clock, rising edge
Reset  input  1  synchronous, active-high reset
Req_Valid  input  1  initiator presents a request
Req_Ready  output  1  responder can accept; high only in IDLE and not in Reset
Req_Write  input  1  1 = store, 0 = load
Req_Addr  input  32  byte address; bits [1:0] ignored, word index = Req_Addr[ADDR_W+1:2]
Req_ByteEn  input  4  lane enables, lane i = bits [8i+7:8i]
Req_WData  input  32  store data, already lane-aligned by initiator
Resp_Valid  output  1  response present, exactly one cycle per accepted request
Resp_RData  output  32  full word read (loads); 0 for stores and errors
Resp_Err  output  1  valid with Resp_Valid; request rejected
Busy  output  1  high whenever state != IDLE

Behaviour:
- Clock port Clk; reset port Reset, synchronous, active-high.
- Reset: state IDLE, counter 0, Resp_Valid 0, Resp_RData 0, Resp_Err 0, Busy 0, Req_Ready 0 during the Reset cycle. All array words cleared to 0. An in-flight request is aborted: no write, no response.
- Handshake: accept on a rising edge where Req_Valid & Req_Ready. Capture Write, Addr, ByteEn and WData into holding registers; later input changes are ignored. Req_Valid in a non-IDLE state is ignored and not queued.
- FSM states: IDLE, WAIT, RESP.
  - IDLE -> WAIT on accept; counter loaded with LATENCY-1.
  - WAIT: if counter == 0, perform the access and go to RESP; otherwise decrement the counter.
  - RESP -> IDLE unconditionally. There is no response backpressure.
- Timing: accept at edge k -> Resp_Valid high in the cycle after edge k+LATENCY. IDLE and Req_Ready return after edge k+LATENCY+1. Throughput is 1 request per LATENCY+2 cycles.
- Access edge, store: for each lane i with ByteEn[i]=1, mem[idx][8i+7:8i] <= WData[8i+7:8i]. Other lanes are unchanged. Resp_RData = 0.
- Access edge, load: Resp_RData <= mem[idx]. ByteEn is still checked for legality; the initiator extracts the lanes it needs.
- Error (Resp_Err=1, no array change, Resp_RData=0) in either case:
  - Req_Addr[31:ADDR_W+2] != 0.
  - ByteEn not in {0001, 0010, 0100, 1000, 0011, 1100, 1111}, which includes 0000.
- Resp_RData and Resp_Err are registered, hold their value only while Resp_Valid=1, and are 0 otherwise.
- Boundary: highest index (all ones) is legal. Index 2^ADDR_W (bit ADDR_W+2 set) is an error, with no wrap-around.
- A store followed by a load to the same word returns the post-store value; accesses are strictly serialized.

Decomposition:
- Package dm_pkg holds:
  - state encoding: IDLE=2'd0, WAIT=2'd1, RESP=2'd2
  - legal ByteEn pattern constants and a be_legal function
  - ADDR_W and LATENCY defaults
- Sub-module dm_ram_array: synchronous byte-enabled word array with Clk, Reset (clear), We, ByteEn, Idx, WData and registered RData. The FSM, counter and error check stay in dm_responder.

Test Plan:
1. Reset mid-WAIT after accepting a store of 0xDEADBEEF to 0x10 -> Resp_Valid never asserts; a following load of 0x10 returns 0.
2. Store 0x12345678 to 0x0 with ByteEn 1111, then load 0x0 (LATENCY=2) -> Resp_Valid high exactly 2 edges after each accept; load RData = 0x12345678, Err = 0.
3. Store 0x0000AB00 with ByteEn 0010 to 0x0, then load 0x0 -> RData = 0x1234AB78.
4. Req_Valid held high continuously -> accepts spaced exactly LATENCY+2 = 4 cycles apart; Busy high for 3 of every 4 cycles.
5. Load at 0x00004000 (ADDR_W=12), and a store with ByteEn 0101 -> Resp_Err = 1, RData = 0, array unchanged.
6. Store to 0x3FFC with ByteEn 1100 and WData 0xCAFE0000, then load 0x3FFC -> RData = 0xCAFE0000, Err = 0.

Source files
------------

// File: rtl/dm_pkg.sv
// Shared definitions for the data-memory responder: state encoding,
// default geometry/latency and the byte-enable legality rule.
package dm_pkg;

    localparam int ADDR_W_DEF  = 12;
    localparam int LATENCY_DEF = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } dm_state_e;

    localparam logic [3:0] BE_B0   = 4'b0001;
    localparam logic [3:0] BE_B1   = 4'b0010;
    localparam logic [3:0] BE_B2   = 4'b0100;
    localparam logic [3:0] BE_B3   = 4'b1000;
    localparam logic [3:0] BE_H0   = 4'b0011;
    localparam logic [3:0] BE_H1   = 4'b1100;
    localparam logic [3:0] BE_WORD = 4'b1111;

    // Only naturally aligned byte, halfword and word lane patterns are accepted.
    function automatic logic be_legal(input logic [3:0] be);
        logic ok;
        case (be)
            BE_B0, BE_B1, BE_B2, BE_B3, BE_H0, BE_H1, BE_WORD: ok = 1'b1;
            default:                                           ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/dm_if.sv
// Load/store request and single-cycle response channel between the M stage
// (master) and the data-memory responder (slave).
interface dm_if;
    logic        Req_Valid;
    logic        Req_Ready;
    logic        Req_Write;
    logic [31:0] Req_Addr;
    logic [3:0]  Req_ByteEn;
    logic [31:0] Req_WData;
    logic        Resp_Valid;
    logic [31:0] Resp_RData;
    logic        Resp_Err;
    logic        Busy;

    modport master (
        output Req_Valid, Req_Write, Req_Addr, Req_ByteEn, Req_WData,
        input  Req_Ready, Resp_Valid, Resp_RData, Resp_Err, Busy
    );

    modport slave (
        input  Req_Valid, Req_Write, Req_Addr, Req_ByteEn, Req_WData,
        output Req_Ready, Resp_Valid, Resp_RData, Resp_Err, Busy
    );
endinterface

// File: rtl/dm_ram_array.sv
// Byte-enabled word array with synchronous clear and a registered read port
// that returns zero on any cycle without a read strobe.
module dm_ram_array
    import dm_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              We,
    input  logic              Re,
    input  logic [3:0]        ByteEn,
    input  logic [ADDR_W-1:0] Idx,
    input  logic [31:0]       WData,
    output logic [31:0]       RData
);

    logic [31:0] mem [2**ADDR_W];

    always_ff @(posedge Clk) begin
        if (Reset) begin
            for (int i = 0; i < 2**ADDR_W; i++) begin
                mem[i] <= '0;
            end
            RData <= '0;
        end else begin
            if (We) begin
                for (int b = 0; b < 4; b++) begin
                    if (ByteEn[b]) begin
                        mem[Idx][8*b +: 8] <= WData[8*b +: 8];
                    end
                end
            end
            RData <= Re ? mem[Idx] : 32'd0;
        end
    end

endmodule

// File: rtl/dm_responder.sv
// Data-memory responder: accepts one load/store at a time, waits a fixed
// latency, then performs the access and returns a one-cycle response.
//
// state | meaning
// IDLE  | ready for a request
// WAIT  | request held, latency counter running; access when it reaches 0
// RESP  | Resp_Valid high for exactly this cycle
module dm_responder
    import dm_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int LATENCY = LATENCY_DEF
) (
    input  logic Clk,
    input  logic Reset,
    dm_if.slave  bus
);

    localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

    dm_state_e   state, state_nxt;
    logic [3:0]  cnt, cnt_nxt;
    logic        do_access;
    logic        accept;
    logic        req_err;
    logic        err_q;

    logic        wr_q;
    logic [31:0] addr_q;
    logic [3:0]  be_q;
    logic [31:0] wdata_q;

    logic [31:0] ram_rdata;

    assign accept  = bus.Req_Valid && bus.Req_Ready;
    // No wrap-around: any address bit above the array span flags an error.
    assign req_err = ((addr_q >> (ADDR_W + 2)) != 32'd0) || !be_legal(be_q);

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        do_access = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = WAIT;
                    cnt_nxt   = LAT_M1;
                end
            end
            WAIT: begin
                if (cnt == 4'd0) begin
                    do_access = 1'b1;
                    state_nxt = RESP;
                end else begin
                    cnt_nxt = cnt - 4'd1;
                end
            end
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            wr_q    <= 1'b0;
            addr_q  <= '0;
            be_q    <= '0;
            wdata_q <= '0;
        end else if (accept) begin
            wr_q    <= bus.Req_Write;
            addr_q  <= bus.Req_Addr;
            be_q    <= bus.Req_ByteEn;
            wdata_q <= bus.Req_WData;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            err_q <= 1'b0;
        end else begin
            err_q <= do_access && req_err;
        end
    end

    dm_ram_array #(
        .ADDR_W (ADDR_W)
    ) u_ram (
        .Clk    (Clk),
        .Reset  (Reset),
        .We     (do_access && wr_q && !req_err),
        .Re     (do_access && !wr_q && !req_err),
        .ByteEn (be_q),
        .Idx    (addr_q[ADDR_W+1:2]),
        .WData  (wdata_q),
        .RData  (ram_rdata)
    );

    assign bus.Req_Ready  = (state == IDLE) && !Reset;
    assign bus.Busy       = (state != IDLE);
    assign bus.Resp_Valid = (state == RESP);
    assign bus.Resp_RData = ram_rdata;
    assign bus.Resp_Err   = err_q;

endmodule

// File: tb/tb_dm_responder.sv
// Directed bench for dm_responder: an edge-indexed reference model predicts
// every output each cycle, and literal expectations pin the key results.
module tb_dm_responder;

    localparam int ADDR_W = 12;
    localparam int L      = 2;
    localparam int NW     = 1 << ADDR_W;

    logic Clk   = 1'b0;
    logic Reset = 1'b1;

    dm_if bus ();

    dm_responder #(
        .ADDR_W  (ADDR_W),
        .LATENCY (L)
    ) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
    );

    always #5 Clk = ~Clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic bit be_ok(input logic [3:0] be);
        return be inside {4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011, 4'b1100, 4'b1111};
    endfunction

    // Reference model: a request accepted at edge k responds after edge k+L
    // and frees the responder after edge k+L+1.
    logic [31:0] m_mem [NW];
    int          edge_n = 0;
    bit          m_active = 1'b0;
    int          m_acc = 0;
    bit          m_wr;
    logic [31:0] m_addr, m_wd;
    logic [3:0]  m_be;
    bit          x_valid = 1'b0, x_err = 1'b0;
    logic [31:0] x_rdata = '0;
    bit          m_acc_pulse = 1'b0;
    int          acc_edges[$];
    bit          chk_en = 1'b0;

    always @(posedge Clk) begin : model
        bit idle_pre;
        int idx;
        edge_n++;
        idle_pre    = !m_active;
        x_valid     = 1'b0;
        x_err       = 1'b0;
        x_rdata     = '0;
        m_acc_pulse = 1'b0;
        if (Reset) begin
            m_active = 1'b0;
            foreach (m_mem[i]) m_mem[i] = '0;
            chk_en = 1'b1;
        end else begin
            if (m_active && edge_n == m_acc + L) begin
                x_valid = 1'b1;
                x_err   = (m_addr >= 32'(NW * 4)) || !be_ok(m_be);
                if (!x_err) begin
                    idx = int'(m_addr / 4);
                    if (m_wr) begin
                        for (int b = 0; b < 4; b++)
                            if (m_be[b]) m_mem[idx][8*b +: 8] = m_wd[8*b +: 8];
                    end else begin
                        x_rdata = m_mem[idx];
                    end
                end
            end
            if (m_active && edge_n == m_acc + L + 1) m_active = 1'b0;
            if (idle_pre && bus.Req_Valid) begin
                m_active    = 1'b1;
                m_acc       = edge_n;
                m_wr        = bus.Req_Write;
                m_addr      = bus.Req_Addr;
                m_be        = bus.Req_ByteEn;
                m_wd        = bus.Req_WData;
                m_acc_pulse = 1'b1;
                acc_edges.push_back(edge_n);
            end
        end
    end

    logic [31:0] last_rdata = '0;
    logic        last_err = 1'b0;
    int          resp_cnt = 0;
    int          resp_edge = 0;

    always @(negedge Clk) begin
        if (chk_en) begin
            check("resp_valid", 32'(bus.Resp_Valid), 32'(x_valid));
            check("resp_rdata", bus.Resp_RData, x_rdata);
            check("resp_err",   32'(bus.Resp_Err), 32'(x_err));
            check("busy",       32'(bus.Busy), 32'(m_active));
            check("req_ready",  32'(bus.Req_Ready), 32'(!m_active && !Reset));
            if (bus.Resp_Valid) begin
                last_rdata = bus.Resp_RData;
                last_err   = bus.Resp_Err;
                resp_cnt++;
                resp_edge  = edge_n;
            end
        end
    end

    int acc_edge = 0;

    task automatic issue(input bit wr, input logic [31:0] addr, input logic [3:0] be,
                         input logic [31:0] wd);
        int n;
        n = 0;
        bus.Req_Valid  = 1'b1;
        bus.Req_Write  = wr;
        bus.Req_Addr   = addr;
        bus.Req_ByteEn = be;
        bus.Req_WData  = wd;
        do begin
            @(posedge Clk); #1;
            n++;
        end while (!m_acc_pulse && n < 50);
        if (!m_acc_pulse) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: no accept after %0d cycles, expected one", n);
        end
        acc_edge = edge_n;
        // Input changes after acceptance must not affect the held request.
        bus.Req_Valid  = 1'b0;
        bus.Req_Write  = ~wr;
        bus.Req_Addr   = 32'hFFFF_FFF0;
        bus.Req_ByteEn = 4'b1111;
        bus.Req_WData  = $urandom;
    endtask

    task automatic req(input bit wr, input logic [31:0] addr, input logic [3:0] be,
                       input logic [31:0] wd);
        issue(wr, addr, be, wd);
        repeat (L + 1) begin
            @(posedge Clk); #1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

    initial begin : stim
        int c0;
        bus.Req_Valid  = 1'b0;
        bus.Req_Write  = 1'b0;
        bus.Req_Addr   = '0;
        bus.Req_ByteEn = '0;
        bus.Req_WData  = '0;
        Reset = 1'b1;
        repeat (3) @(posedge Clk);
        #1 Reset = 1'b0;
        @(posedge Clk); #1;

        // 1: reset while the store waits aborts it
        c0 = resp_cnt;
        issue(1'b1, 32'h10, 4'b1111, 32'hDEAD_BEEF);
        Reset = 1'b1;
        @(posedge Clk); #1;
        Reset = 1'b0;
        repeat (4) begin
            @(posedge Clk); #1;
        end
        check("t1_no_resp", resp_cnt, c0);
        req(1'b0, 32'h10, 4'b1111, 32'h0);
        check("t1_load_rdata", last_rdata, 32'h0);

        // 2: full-word store then load, latency from accept to response
        req(1'b1, 32'h0, 4'b1111, 32'h1234_5678);
        check("t2_store_latency", resp_edge - acc_edge, 2);
        check("t2_store_rdata", last_rdata, 32'h0);
        req(1'b0, 32'h0, 4'b1111, 32'h0);
        check("t2_load_latency", resp_edge - acc_edge, 2);
        check("t2_load_rdata", last_rdata, 32'h1234_5678);
        check("t2_load_err", 32'(last_err), 32'h0);

        // 3: single-lane store merges into the existing word
        req(1'b1, 32'h0, 4'b0010, 32'h0000_AB00);
        req(1'b0, 32'h0, 4'b1111, 32'h0);
        check("t3_rdata", last_rdata, 32'h1234_AB78);

        // 4: Req_Valid held high, accepts spaced by LATENCY+2
        acc_edges.delete();
        bus.Req_Valid  = 1'b1;
        bus.Req_Write  = 1'b0;
        bus.Req_Addr   = 32'h0;
        bus.Req_ByteEn = 4'b1111;
        repeat (14) begin
            @(posedge Clk); #1;
        end
        bus.Req_Valid = 1'b0;
        repeat (6) begin
            @(posedge Clk); #1;
        end
        check("t4_accept_count", 32'(acc_edges.size() >= 3), 32'h1);
        for (int i = 1; i < acc_edges.size(); i++)
            check("t4_spacing", acc_edges[i] - acc_edges[i-1], 4);
        check("t4_rdata", last_rdata, 32'h1234_AB78);

        // 5: errors leave the array untouched
        req(1'b0, 32'h0000_4000, 4'b1111, 32'h0);
        check("t5_oob_err", 32'(last_err), 32'h1);
        check("t5_oob_rdata", last_rdata, 32'h0);
        req(1'b1, 32'h0, 4'b0101, 32'hFFFF_FFFF);
        check("t5_be_err", 32'(last_err), 32'h1);
        req(1'b1, 32'h0000_4000, 4'b1111, 32'hFFFF_FFFF);
        check("t5_nowrap_err", 32'(last_err), 32'h1);
        req(1'b0, 32'h8000_0000, 4'b1111, 32'h0);
        check("t5_hibit_err", 32'(last_err), 32'h1);
        req(1'b0, 32'h0, 4'b0000, 32'h0);
        check("t5_be0_err", 32'(last_err), 32'h1);
        check("t5_be0_rdata", last_rdata, 32'h0);
        req(1'b0, 32'h0, 4'b1111, 32'h0);
        check("t5_unchanged", last_rdata, 32'h1234_AB78);
        check("t5_ok_err", 32'(last_err), 32'h0);

        // 6: highest word, upper halfword store
        req(1'b1, 32'h3FFC, 4'b1100, 32'hCAFE_0000);
        check("t6_store_err", 32'(last_err), 32'h0);
        req(1'b0, 32'h3FFC, 4'b1111, 32'h0);
        check("t6_rdata", last_rdata, 32'hCAFE_0000);
        check("t6_err", 32'(last_err), 32'h0);

        repeat (3) @(posedge Clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
